// File: rtl/result_writeback_packer.sv
`default_nettype none
// ============================================================================
// Module   : result_writeback_packer
// Brief    : Requantizes 32-bit activated results to int8 and packs four per
//            little-endian word onto an addressed valid/ready write port.
// Revision : 1.0
// ============================================================================
module result_writeback_packer #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_results,
    input  logic [4:0]        shift_amt,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] base_q,     base_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [4:0]        shift_q,    shift_d;
    logic [1:0]        lane_q,     lane_d;
    logic [31:0]       pack_q,     pack_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [31:0]       wr_data_q,  wr_data_d;
    logic [3:0]        wr_strb_q,  wr_strb_d;

    logic signed [32:0] rnd_add;
    logic signed [32:0] sum_ext;
    logic signed [32:0] shifted;
    logic [7:0]         q_byte;
    logic               last_result;
    logic               word_complete;
    logic               can_accept;
    logic               accept;
    logic               wr_fire;
    logic [31:0]        merged_data;
    logic [3:0]         merged_strb;

    // Round-half-up arithmetic shift; the 33-bit sum keeps the rounding add from wrapping.
    always_comb begin
        rnd_add = '0;
        if (shift_q != 5'd0) begin
            rnd_add = 33'sd1 <<< (shift_q - 5'd1);
        end
        sum_ext = $signed({in_data[31], in_data}) + rnd_add;
        shifted = sum_ext >>> shift_q;
        if (shifted > 33'sd127) begin
            q_byte = 8'h7F;
        end else if (shifted < -33'sd128) begin
            q_byte = 8'h80;
        end else begin
            q_byte = shifted[7:0];
        end
    end

    always_comb begin
        merged_data = pack_q;
        merged_strb = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (lane_q == 2'(k)) begin
                merged_data[8*k +: 8] = q_byte;
            end
            merged_strb[k] = (lane_q >= 2'(k));
        end
    end

    assign last_result   = (remaining_q == CNT_W'(1));
    assign word_complete = last_result || (lane_q == 2'd3);
    // A word-completing accept needs the output register free (or freeing this cycle).
    assign can_accept    = (state_q == S_RUN) && (remaining_q != '0) &&
                           (!wr_valid_q || wr_ready || !word_complete);
    assign accept        = in_valid && can_accept;
    assign wr_fire       = wr_valid_q && wr_ready;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        remaining_d = remaining_q;
        shift_d     = shift_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        word_idx_d  = word_idx_q;
        wr_valid_d  = wr_valid_q && !wr_ready;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_strb_d   = wr_strb_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_results != '0) begin
                        base_d      = base_addr;
                        remaining_d = num_results;
                        shift_d     = shift_amt;
                        lane_d      = 2'd0;
                        pack_d      = '0;
                        word_idx_d  = '0;
                        state_d     = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (word_complete) begin
                        wr_valid_d = 1'b1;
                        wr_data_d  = merged_data;
                        wr_strb_d  = merged_strb;
                        wr_addr_d  = base_q + (ADDR_W'(word_idx_q) << 2);
                        word_idx_d = word_idx_q + CNT_W'(1);
                        lane_d     = 2'd0;
                        pack_d     = '0;
                    end else begin
                        pack_d = merged_data;
                        lane_d = lane_q + 2'd1;
                    end
                    if (last_result) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (wr_fire) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            lane_q      <= '0;
            pack_q      <= '0;
            word_idx_q  <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            word_idx_q  <= word_idx_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_strb_q   <= wr_strb_d;
        end
    end

    assign in_ready = can_accept;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_strb  = wr_strb_q;
    assign busy     = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_result_writeback_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_writeback_packer
// Brief    : Randomized jobs against a stream-level model of the packer.
// Revision : 1.0
// ============================================================================
module tb_result_writeback_packer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_results;
    logic [4:0]  shift_amt;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int ready_pct = 100;
    int hold_cnt = 0;
    int hold_wait;
    int base_n;
    int rj_n;
    int rj_sh;
    logic [31:0] rj_base;
    logic [31:0] stim[$];
    wr_t exp_q[$];
    wr_t log_q[$];

    // Model state, updated once per cycle on the falling edge
    int          m_rem, m_acc, m_words, m_lanes;
    bit          m_open, m_run, m_done_due, m_hold, m_expv, m_expr, m_hs;
    logic [31:0] m_base, m_cur;
    logic [3:0]  m_strb;
    logic [4:0]  m_shift;
    logic [7:0]  m_b;
    wr_t         m_prev, m_w;

    result_writeback_packer #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .num_results (num_results),
        .shift_amt   (shift_amt),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requantization from its arithmetic definition: round half up, divide by 2^s, clamp.
    function automatic logic [7:0] quant(input logic signed [31:0] x, input int s);
        longint v;
        v = x;
        if (s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    function automatic logic [31:0] rand_data();
        int sel;
        sel = $urandom_range(0, 4);
        case (sel)
            0:       return 32'($urandom);
            1:       return 32'($urandom_range(0, 400)) - 32'd200;
            2:       return 32'($urandom_range(0, 65535)) - 32'd32768;
            3:       return 32'h7FFF_FFFF;
            default: return 32'h8000_0000;
        endcase
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (hold_cnt > 0) begin
            wr_ready = 1'b0;
            hold_cnt--;
        end else begin
            wr_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_open = 0; m_run = 0; m_done_due = 0; m_hold = 0;
            m_rem = 0; m_acc = 0; m_words = 0; m_lanes = 0;
            m_cur = '0; m_strb = '0;
        end else begin
            m_expv = (exp_q.size() != 0);
            check("wr_valid", {63'd0, wr_valid}, {63'd0, m_expv});
            check("busy", {63'd0, busy}, {63'd0, m_open && !m_done_due});
            check("done", {63'd0, done}, {63'd0, m_done_due});
            m_expr = m_run && (m_rem != 0) &&
                     (!m_expv || wr_ready || !(((m_acc % 4) == 3) || (m_rem == 1)));
            check("in_ready", {63'd0, in_ready}, {63'd0, m_expr});
            if (m_hold) begin
                check("hold_stable", {28'd0, wr_addr, wr_strb}, {28'd0, m_prev.addr, m_prev.strb});
                check("hold_data", {32'd0, wr_data}, {32'd0, m_prev.data});
            end
            if (m_done_due) begin
                m_done_due = 0;
                m_open = 0;
            end
            m_hs = wr_valid && wr_ready;
            if (m_hs) begin
                m_w = '{addr: wr_addr, data: wr_data, strb: wr_strb};
                log_q.push_back(m_w);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {28'd0, m_w.addr, m_w.strb}, 64'd0);
                end else begin
                    check("wr_addr", {32'd0, m_w.addr}, {32'd0, exp_q[0].addr});
                    check("wr_data", {32'd0, m_w.data}, {32'd0, exp_q[0].data});
                    check("wr_strb", {60'd0, m_w.strb}, {60'd0, exp_q[0].strb});
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                m_b = quant($signed(in_data), int'(m_shift));
                m_cur = m_cur | (32'(m_b) << (8 * m_lanes));
                m_strb[m_lanes] = 1'b1;
                m_lanes++; m_acc++; m_rem--;
                if (m_lanes == 4 || m_rem == 0) begin
                    exp_q.push_back('{addr: m_base + 32'(4 * m_words), data: m_cur, strb: m_strb});
                    m_words++; m_lanes = 0; m_cur = '0; m_strb = '0;
                end
                if (m_rem == 0) m_run = 0;
            end
            if (m_hs && m_open && !m_run && m_rem == 0 && exp_q.size() == 0) m_done_due = 1;
            if (start && !busy && !done) begin
                m_base = base_addr; m_shift = shift_amt;
                m_rem = int'(num_results); m_acc = 0; m_words = 0;
                m_lanes = 0; m_cur = '0; m_strb = '0;
                if (num_results == 16'd0) begin
                    m_done_due = 1;
                end else begin
                    m_open = 1; m_run = 1;
                end
            end
            m_hold = wr_valid && !wr_ready;
            m_prev = '{addr: wr_addr, data: wr_data, strb: wr_strb};
        end
    end

    task automatic run_job(input logic [31:0] b, input int n, input int sh, input int vpct, input bit inj);
        int idx;
        int cyc;
        bit acc;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_results = 16'(n); shift_amt = 5'(sh);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < n && cyc < 2000) begin
            in_valid = ($urandom_range(0, 99) < vpct);
            in_data  = stim[idx];
            start    = inj && (cyc == 3);
            if (start) begin
                num_results = 16'd3; base_addr = 32'hDEAD_0000;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0;
        if (idx < n) check("feed_timeout", 64'(idx), 64'(n));
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 400);
        if (!done) check("done_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_word(input string name, input int i, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s);
        if (i >= log_q.size()) begin
            check(name, 64'(log_q.size()), 64'(i + 1));
        end else begin
            check(name, {log_q[i].addr, log_q[i].data}, {a, d});
            check(name, {60'd0, log_q[i].strb}, {60'd0, s});
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {36'd0, in_ready, wr_valid, wr_strb, busy, done, 16'd0},
              64'd0);
        check(name, {wr_addr, wr_data}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_results = '0;
        shift_amt = '0; in_valid = 1'b0; in_data = '0; wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        rst_n = 1'b1;

        check("model_q8_s4", {56'd0, quant(32'sd8, 4)}, 64'h01);
        check("model_qm9_s4", {56'd0, quant(-32'sd9, 4)}, 64'hFF);
        check("model_q24_s4", {56'd0, quant(32'sd24, 4)}, 64'h02);
        check("model_qmax_s31", {56'd0, quant(32'sh7FFF_FFFF, 31)}, 64'h01);

        // Single word
        ready_pct = 100; base_n = log_q.size();
        stim = '{32'd1, 32'hFFFF_FFFF, 32'd127, 32'hFFFF_FF80};
        run_job(32'h1000, 4, 0, 100, 0);
        check("single_count", 64'(log_q.size() - base_n), 64'd1);
        check_word("single_word", base_n, 32'h1000, 32'h807F_FF01, 4'hF);

        // Rounding and saturation
        base_n = log_q.size();
        stim = '{32'd24, -32'd24, 32'd5000, -32'd5000};
        run_job(32'h1100, 4, 4, 100, 0);
        check_word("round_sat", base_n, 32'h1100, 32'h807F_FF02, 4'hF);

        // Partial tail and address stepping
        base_n = log_q.size();
        stim = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        run_job(32'h2000, 6, 0, 100, 0);
        check("tail_count", 64'(log_q.size() - base_n), 64'd2);
        check_word("tail_w0", base_n, 32'h2000, 32'h0403_0201, 4'hF);
        check_word("tail_w1", base_n + 1, 32'h2004, 32'h0000_0605, 4'h3);

        // Backpressure: ready held low five cycles after first valid
        base_n = log_q.size(); ready_pct = 0;
        stim = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        fork
            run_job(32'h4000, 8, 0, 100, 0);
            begin
                hold_wait = 0;
                while (!wr_valid && hold_wait < 200) begin
                    @(negedge clk);
                    hold_wait++;
                end
                hold_cnt = 5; ready_pct = 100;
            end
        join
        check("bp_count", 64'(log_q.size() - base_n), 64'd2);
        check_word("bp_w0", base_n, 32'h4000, 32'h0403_0201, 4'hF);
        check_word("bp_w1", base_n + 1, 32'h4004, 32'h0807_0605, 4'hF);

        // Zero count
        base_n = log_q.size();
        run_job(32'h5000, 0, 0, 100, 0);
        check("zero_no_write", 64'(log_q.size() - base_n), 64'd0);

        // Start pulsed mid-job is ignored
        base_n = log_q.size();
        stim = '{32'd9, 32'd10, 32'd11, 32'd12, 32'd13};
        run_job(32'h5100, 5, 0, 60, 1);
        check("ignstart_count", 64'(log_q.size() - base_n), 64'd2);
        check_word("ignstart_w1", base_n + 1, 32'h5104, 32'h0000_000D, 4'h1);

        // Randomized jobs
        for (int j = 0; j < 30; j++) begin
            rj_n = $urandom_range(1, 13);
            rj_sh = $urandom_range(0, 31);
            rj_base = 32'($urandom) & 32'hFFFF_FFFC;
            stim.delete();
            for (int i = 0; i < rj_n; i++) stim.push_back(rand_data());
            ready_pct = $urandom_range(30, 100);
            run_job(rj_base, rj_n, rj_sh, $urandom_range(30, 100), 0);
        end

        // Reset mid-job while a word is pending
        ready_pct = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h6000; num_results = 16'd8; shift_amt = 5'd0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 32'd3;
        hold_wait = 0;
        while (!wr_valid && hold_wait < 50) begin
            @(negedge clk);
            hold_wait++;
        end
        check("pre_reset_valid", {63'd0, wr_valid}, 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; ready_pct = 100;
        base_n = log_q.size();
        stim = '{32'd17, 32'd34, 32'd51, 32'd68};
        run_job(32'h7000, 4, 0, 100, 0);
        check("post_reset_count", 64'(log_q.size() - base_n), 64'd1);
        check_word("post_reset_w0", base_n, 32'h7000, 32'h4433_2211, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
